delay_uart_tx: RTL and testbench
================================

# delay_uart_tx

Downstream consumer stage for the 8-bit delay-line shift register. It accepts the bytes leaving the delay line over a valid/ready handshake, buffers them in a small FIFO, and serializes each byte as an 8N1 UART frame on a single output pin. In the top level, `tx` drives `uo_out[0]`. Deasserting `in_ready` is the delay line's signal to hold `shift_enable` low, so it stalls rather than losing bytes.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range ≥ 2.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of two, ≥ 2.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: byte from the delay line output.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: FIFO can accept a byte this cycle.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress (any state other than IDLE).
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** a byte is pushed when `in_valid && in_ready` at a rising edge.
- **`in_ready`:** equals `fifo_level != FIFO_DEPTH`. It is registered state, with no combinational path from pop to ready.
- **FIFO:** circular, with write and read pointers that wrap at FIFO_DEPTH.
- **Simultaneous push and pop:** `fifo_level` is unchanged and both pointers advance.
- **FSM states:** IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: `tx`=1. If `fifo_level` != 0, pop the head byte into the shift register, clear the baud and bit counters, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx` = shift register bit 0. Shift right every CLKS_PER_BIT cycles. After 8 bits, go to STOP (or PARITY when compiled in).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if FIFO is non-empty, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **Bit order:** LSB first.
- **Counters:**
  - baud counter counts 0..CLKS_PER_BIT-1 and wraps;
  - bit counter counts 0..7;
  - neither counter ever exceeds its bound.
- **`tx` drive:** registered, so it is glitch-free.
- **Pushes while busy:** accepted normally until the FIFO is full.
- **Reset:** when asserted mid-frame, the frame is aborted immediately. All outputs take their reset values:
  - `tx`=1
  - `busy`=0
  - `fifo_level`=0
  - `in_ready`=1
  - FIFO contents discarded
  - FSM in IDLE.

## Timing
- **Push to start bit:** a push at edge E into an empty, idle block gives a pop at edge E+1. `tx` falls after E+1.
- **Bit durations:** start bit lasts exactly CLKS_PER_BIT cycles. Each data bit and the stop bit also last CLKS_PER_BIT cycles.
- **Frame length:** 10·CLKS_PER_BIT cycles (11· with parity).
- **Back-to-back throughput:** one frame per frame length, with no extra cycle between frames.
- **`busy`:** rises the cycle after the pop edge, together with the `tx` fall. It falls with the IDLE entry.
- **`fifo_level`:** reflects pushes and pops the cycle after the edge.

## Configuration
- **`DELAY_UART_PARITY_EN` defined:**
  - adds a PARITY state between DATA and STOP;
  - `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles;
  - frame is 11 bits.
- **`DELAY_UART_PARITY_EN` undefined:**
  - no PARITY state and no parity logic;
  - DATA goes directly to STOP;
  - frame is 10 bits.

## Test plan
- **Reset values:** hold `rst_n`=0 with random inputs → `tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0. Release `rst_n` → values remain until the first push.
- **Single frame:** CLKS_PER_BIT=4, push 0xA5 → `tx` gives 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `busy` is high for 40 cycles, then returns to IDLE.
- **Back-to-back frames:** push 0x00, 0xFF, 0x3C in consecutive cycles → three contiguous frames with no idle cycle between the stop bit and the next start bit. `fifo_level` peaks at 2.
- **Full FIFO and backpressure:** FIFO_DEPTH=4, hold `in_valid`=1 with 0x10..0x17 during transmission. `in_ready` drops when level reaches 4, and no byte is lost or duplicated. Expected output order is 0x10..0x17.
- **Reset mid-operation:** assert `rst_n`=0 during the DATA bit 3 of 0x5A with 2 bytes queued → `tx`=1 immediately and `fifo_level`=0. After release, no further frame is emitted.
- **Parity (`DELAY_UART_PARITY_EN` defined):** push 0xA5 → parity bit 0. Push 0x01 → parity bit 1. Each frame lasts 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/delay_uart_tx.sv
// Byte FIFO feeding an 8N1 UART serializer, fed by the delay-line shift register.
// Define DELAY_UART_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps
module delay_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DELAY_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_d;
  logic          push, pop;
  logic [7:0]    head;

  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];

  always_comb begin
    level_d = fifo_level;
    case ({push, pop})
      2'b10:   level_d = fifo_level + LW'(1);
      2'b01:   level_d = fifo_level - LW'(1);
      default: level_d = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Ready is precomputed from next level so pop never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_d;
      in_ready   <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  // ---------------- serializer ----------------
  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d;
  logic          baud_end;
  logic          fifo_nonempty;

  assign baud_end      = (baud == BW'(CLKS_PER_BIT - 1));
  assign fifo_nonempty = (fifo_level != '0);

`ifdef DELAY_UART_PARITY_EN
  logic par, par_d;
`endif

  always_comb begin
    state_d = state;
    baud_d  = baud_end ? '0 : baud + BW'(1);
    bit_d   = bit_cnt;
    shreg_d = shreg;
    pop     = 1'b0;
`ifdef DELAY_UART_PARITY_EN
    par_d   = par;
`endif
    case (state)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = S_START;
          bit_d   = '0;
          shreg_d = head;
`ifdef DELAY_UART_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef DELAY_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shreg_d = {1'b0, shreg[7:1]};
            bit_d   = bit_cnt + 3'd1;
          end
        end
      end
`ifdef DELAY_UART_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (baud_end) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = S_START;
            bit_d   = '0;
            shreg_d = head;
`ifdef DELAY_UART_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // Line level is decoded from the next state so tx leaves a flop.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef DELAY_UART_PARITY_EN
      S_PARITY: tx_d = par;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
      busy    <= (state_d != S_IDLE);
    end
  end

`ifdef DELAY_UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= par_d;
  end
`endif

endmodule

// File: tb/tb_delay_uart_tx.sv
// Directed bench for delay_uart_tx: a line monitor decodes frames, main block checks them.
`timescale 1ns/1ps
module tb_delay_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef DELAY_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  delay_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic       par;
    bit         ok;
    int         gap;
  } frame_t;
  frame_t rxq[$];

  // Line monitor: decodes each frame, checks every bit is held CPB cycles with busy high.
  bit         mon_en = 0;
  bit         in_frame = 0;
  int         cnt = 0, mb = 0, idle_cnt = 1000, peak = 0;
  logic [7:0] cur_d;
  logic       cur_par, cur_bit;
  bit         cur_ok;
  int         cur_gap;
  frame_t     f_m;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      in_frame = 0;
      idle_cnt = 1000;
    end else begin
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1; cnt = 0; cur_ok = 1; cur_d = '0; cur_par = 1'b0; cur_gap = idle_cnt;
      end
      if (in_frame) begin
        mb = cnt / CPB;
        if (cnt % CPB == 0) begin
          cur_bit = tx;
          if (mb >= 1 && mb <= 8) cur_d[mb-1] = tx;
          else if (mb == NB - 1) begin
            if (tx !== 1'b1) cur_ok = 0;
          end else if (mb == 9) cur_par = tx;
        end else if (tx !== cur_bit) cur_ok = 0;
        if (busy !== 1'b1) cur_ok = 0;
        cnt++;
        if (cnt == NB * CPB) begin
          in_frame = 0;
          idle_cnt = 0;
          f_m.d = cur_d; f_m.par = cur_par; f_m.ok = cur_ok; f_m.gap = cur_gap;
          rxq.push_back(f_m);
        end
      end else idle_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c = 0;
    while (rxq.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic chk_frame(input logic [7:0] exp, input int exp_gap, input string tag);
    frame_t f;
    chk({tag, ".present"}, 32'(rxq.size() != 0), 32'd1);
    if (rxq.size() == 0) return;
    f = rxq.pop_front();
    chk({tag, ".data"}, 32'(f.d), 32'(exp));
    chk({tag, ".shape"}, 32'(f.ok), 32'd1);
    if (exp_gap >= 0) chk({tag, ".gap"}, f.gap, exp_gap);
`ifdef DELAY_UART_PARITY_EN
    chk({tag, ".par"}, 32'(f.par), 32'(^exp));
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".tx"}, 32'(tx), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".level"}, 32'(fifo_level), 32'd0);
  endtask

  int  idx, guard, low_cnt;
  bit  acc, saw_full, rdy_bad;

  initial begin
    // Reset with random inputs, then release.
    #3 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      step();
    end
    chk_idle("rst_hold");
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(); step(); step();
    chk_idle("rst_release");
    mon_en = 1;

    // Single frame 0xA5: pop one edge after push, tx falls with busy.
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single.level_after_push", 32'(fifo_level), 32'd1);
    chk("single.tx_before_pop", 32'(tx), 32'd1);
    chk("single.busy_before_pop", 32'(busy), 32'd0);
    step();
    chk("single.tx_start", 32'(tx), 32'd0);
    chk("single.busy_start", 32'(busy), 32'd1);
    chk("single.level_after_pop", 32'(fifo_level), 32'd0);
    wait_frames(1, NB * CPB + 10, "single.wait");
    chk_frame(8'hA5, -1, "single");
    step();
    chk("single.busy_end", 32'(busy), 32'd0);
    chk("single.tx_end", 32'(tx), 32'd1);

`ifdef DELAY_UART_PARITY_EN
    in_data = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_frames(1, NB * CPB + 10, "par01.wait");
    chk_frame(8'h01, -1, "par01");
`endif

    // Back-to-back frames, no idle between stop and next start.
    step(); step();
    peak = 0;
    in_valid = 1'b1; in_data = 8'h00;
    step();
    chk("b2b.level0", 32'(fifo_level), 32'd1);
    in_data = 8'hFF;
    step();
    chk("b2b.level1", 32'(fifo_level), 32'd1);
    in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("b2b.level2", 32'(fifo_level), 32'd2);
    wait_frames(3, 3 * NB * CPB + 20, "b2b.wait");
    chk_frame(8'h00, -1, "b2b0");
    chk_frame(8'hFF, 0, "b2b1");
    chk_frame(8'h3C, 0, "b2b2");
    chk("b2b.peak", peak, 2);

    // Backpressure: stream 0x10..0x17 with valid held, ready follows level.
    step(); step();
    idx = 0; guard = 0; saw_full = 0; rdy_bad = 0;
    while (idx < 8 && guard < 2000) begin
      in_data  = 8'(16 + idx);
      in_valid = 1'b1;
      acc = in_ready;
      if (fifo_level == 3'd4) saw_full = 1;
      if (in_ready !== (fifo_level != 3'd4)) rdy_bad = 1;
      step();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("full.accepted", idx, 8);
    chk("full.saw_full", 32'(saw_full), 32'd1);
    chk("full.ready_vs_level", 32'(rdy_bad), 32'd0);
    wait_frames(8, 8 * NB * CPB + 50, "full.wait");
    for (int i = 0; i < 8; i++)
      chk_frame(8'(16 + i), (i == 0) ? -1 : 0, $sformatf("full%0d", i));

    // Reset during data bit 3 of 0x5A with two bytes queued.
    step(); step();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    chk("abort.level_before", 32'(fifo_level), 32'd2);
    for (int i = 0; i < 16; i++) step();
    chk("abort.busy_before", 32'(busy), 32'd1);
    chk("abort.tx_bit3", 32'(tx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort.during_reset");
    step(); step();
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (tx !== 1'b1) low_cnt++;
    end
    chk("abort.tx_low_after", low_cnt, 0);
    chk("abort.frames_after", rxq.size(), 0);
    chk_idle("abort.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
